// File: rtl/eatup_pkg.sv
// rtl/eatup_pkg.sv - shared state encoding and BCD helpers for the EatUp game blocks
package eatup_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Values above 99 wrap modulo 100 so the result always fits two digits.
  function automatic logic [2*BCD_W-1:0] to_bcd(input int unsigned value);
    int unsigned v;
    v = value % 100;
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// rtl/rising_edge_detect.sv - registered one-cycle pulse on each 0->1 transition of in
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= in;
      pulse_q <= in & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/game_countdown_timer.sv
// rtl/game_countdown_timer.sv - two-digit BCD round timer driven by the 1-second divider output
module game_countdown_timer
  import eatup_pkg::*;
#(
  parameter int unsigned START_SECONDS = 60,
  parameter int unsigned WARN_SECONDS  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             start,
  input  logic             pause,
  output logic [BCD_W-1:0] secs_tens,
  output logic [BCD_W-1:0] secs_ones,
  output logic             running,
  output logic             low_time,
  output logic             expired,
  output logic             time_up
);

  localparam logic [2*BCD_W-1:0] START_BCD  = to_bcd(START_SECONDS);
  localparam logic [6:0]         WARN_BIN   = 7'(WARN_SECONDS);
  localparam logic               START_ZERO = (START_SECONDS == 0);

  logic             tick_edge;
  state_e           state_q, state_d;
  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;
  logic             expired_q, expired_d;
  logic             running_q, low_q, time_up_q;
  logic [6:0]       remain_d;
  logic             low_d;

  rising_edge_detect u_tick_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (tick_in),
    .pulse (tick_edge)
  );

  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    expired_d = 1'b0;
    if (start) begin
      tens_d = START_BCD[2*BCD_W-1:BCD_W];
      ones_d = START_BCD[BCD_W-1:0];
      if (START_ZERO) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick_edge) begin
            if (ones_q == 4'd0) begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end else begin
              ones_d = ones_q - 4'd1;
            end
          end
          // Reaching 00 takes precedence over a coincident pause.
          if (tick_edge && tens_q == 4'd0 && ones_q == 4'd1) begin
            state_d   = ST_DONE;
            expired_d = 1'b1;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (pause) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  // Flags are registered from next-state values so they line up with the digits.
  always_comb begin
    remain_d = 7'({3'b000, tens_d} * 7'd10) + {3'b000, ones_d};
    low_d    = (state_d == ST_RUN || state_d == ST_PAUSED) &&
               (remain_d != 7'd0) && (remain_d <= WARN_BIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tens_q    <= START_BCD[2*BCD_W-1:BCD_W];
      ones_q    <= START_BCD[BCD_W-1:0];
      expired_q <= 1'b0;
      running_q <= 1'b0;
      low_q     <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      expired_q <= expired_d;
      running_q <= (state_d == ST_RUN);
      low_q     <= low_d;
      time_up_q <= (state_d == ST_DONE);
    end
  end

  assign secs_tens = tens_q;
  assign secs_ones = ones_q;
  assign running   = running_q;
  assign low_time  = low_q;
  assign expired   = expired_q;
  assign time_up   = time_up_q;

endmodule
